// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
//
// Instruction-fetch stage. Holds the fetch PC, runs a single-outstanding
// request/response handshake to instruction memory, and owns the IF/ID
// output register. A one-entry skid buffer catches a response that lands
// while decode is stalled. A taken branch or jump from EX (pcsel_i) redirects
// the PC, squashes the IF/ID register and skid, and discards any response
// still in flight.
//
// Ports
//   clk, rst         core clock, synchronous active-high reset
//   pcsel_i          0: sequential PC+4, 1: redirect to alu_target_i
//   alu_target_i     redirect target (low two bits ignored)
//   stall_i          decode cannot accept; hold IF/ID
//   imem_req_o       fetch request valid
//   imem_addr_o      fetch address (word aligned)
//   imem_gnt_i       request accepted this cycle
//   imem_rvalid_i    response valid (never in the grant cycle)
//   imem_rdata_i     instruction word
//   pc_o, inst_o     IF/ID register contents
//   inst_valid_o     inst_o is a real instruction
//   flush_o          squash the instruction entering ID/EX (combinational)
// ---------------------------------------------------------------------------
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcsel_i,
    input  logic [31:0] alu_target_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        flush_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] fetch_pc_reg, fetch_pc_next;
    logic [31:0] req_pc_reg, req_pc_next;
    logic        skid_valid_reg, skid_valid_next;
    logic [31:0] skid_pc_reg, skid_pc_next;
    logic [31:0] skid_inst_reg, skid_inst_next;
    logic [31:0] out_pc_reg, out_pc_next;
    logic [31:0] out_inst_reg, out_inst_next;
    logic        out_valid_reg, out_valid_next;

    logic        redirect;
    logic [31:0] target;
    logic        grant;
    logic        deliver;
    logic        unused_target_bits;

    assign redirect = pcsel_i;
    assign target   = {alu_target_i[31:2], 2'b00};
    assign unused_target_bits = ^alu_target_i[1:0];

    // A full skid blocks new requests, so a delivery can never find the
    // skid already occupied.
    assign imem_req_o  = (state_reg == REQ) & ~skid_valid_reg;
    assign imem_addr_o = fetch_pc_reg;
    assign grant       = imem_req_o & imem_gnt_i;
    // Only a response in WAIT without a concurrent redirect is kept; in DROP
    // (or on a redirect) the data belongs to the wrong path.
    assign deliver     = (state_reg == WAIT) & imem_rvalid_i & ~redirect;

    assign flush_o      = pcsel_i & ~rst;
    assign pc_o         = out_pc_reg;
    assign inst_o       = out_inst_reg;
    assign inst_valid_o = out_valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            fetch_pc_reg   <= RESET_PC;
            req_pc_reg     <= RESET_PC;
            skid_valid_reg <= 1'b0;
            skid_pc_reg    <= RESET_PC;
            skid_inst_reg  <= NOP_INST;
            out_pc_reg     <= RESET_PC;
            out_inst_reg   <= NOP_INST;
            out_valid_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            fetch_pc_reg   <= fetch_pc_next;
            req_pc_reg     <= req_pc_next;
            skid_valid_reg <= skid_valid_next;
            skid_pc_reg    <= skid_pc_next;
            skid_inst_reg  <= skid_inst_next;
            out_pc_reg     <= out_pc_next;
            out_inst_reg   <= out_inst_next;
            out_valid_reg  <= out_valid_next;
        end
    end

    // Fetch FSM and PC update
    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        req_pc_next   = req_pc_reg;

        case (state_reg)
            IDLE: state_next = REQ;
            REQ: begin
                if (grant) begin
                    req_pc_next   = fetch_pc_reg;
                    fetch_pc_next = fetch_pc_reg + 32'd4;
                    state_next    = redirect ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    state_next = REQ;
                end else if (redirect) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid_i) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase

        // Redirect target wins over the sequential increment.
        if (redirect) begin
            fetch_pc_next = target;
        end
    end

    // IF/ID register and skid buffer
    always_comb begin
        skid_valid_next = skid_valid_reg;
        skid_pc_next    = skid_pc_reg;
        skid_inst_next  = skid_inst_reg;
        out_pc_next     = out_pc_reg;
        out_inst_next   = out_inst_reg;
        out_valid_next  = out_valid_reg;

        if (redirect) begin
            out_valid_next  = 1'b0;
            out_inst_next   = NOP_INST;
            skid_valid_next = 1'b0;
        end else if (deliver) begin
            if (!out_valid_reg || !stall_i) begin
                out_pc_next    = req_pc_reg;
                out_inst_next  = imem_rdata_i;
                out_valid_next = 1'b1;
            end else begin
                skid_valid_next = 1'b1;
                skid_pc_next    = req_pc_reg;
                skid_inst_next  = imem_rdata_i;
            end
        end else if (!stall_i) begin
            if (skid_valid_reg) begin
                out_pc_next     = skid_pc_reg;
                out_inst_next   = skid_inst_reg;
                out_valid_next  = 1'b1;
                skid_valid_next = 1'b0;
            end else begin
                // pc_o deliberately holds its last value
                out_valid_next = 1'b0;
                out_inst_next  = NOP_INST;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch: self-checking bench for if_fetch.
// The bench acts as instruction memory: it grants every request when
// auto_gnt is set and answers lat cycles after the cycle following the
// grant, with data = address + 0x100. Responses expected to reach decode are
// queued and compared as decode consumes them (inst_valid_o & ~stall_i).
// A second instance with RESET_PC = 0xFFFF_FFFC exercises PC wrap.
// ---------------------------------------------------------------------------
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        pcsel_i;
    logic [31:0] alu_target_i;
    logic        stall_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        flush_o;

    logic        u2_req;
    logic [31:0] u2_addr;
    logic [31:0] u2_pc;
    logic [31:0] u2_inst;
    logic        u2_valid;
    logic        u2_flush;

    if_fetch #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .pcsel_i(pcsel_i), .alu_target_i(alu_target_i),
        .stall_i(stall_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i(imem_rdata_i), .pc_o(pc_o), .inst_o(inst_o),
        .inst_valid_o(inst_valid_o), .flush_o(flush_o)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(NOP)) dut_wrap (
        .clk(clk), .rst(rst), .pcsel_i(pcsel_i), .alu_target_i(alu_target_i),
        .stall_i(stall_i), .imem_req_o(u2_req), .imem_addr_o(u2_addr),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i(imem_rdata_i), .pc_o(u2_pc), .inst_o(u2_inst),
        .inst_valid_o(u2_valid), .flush_o(u2_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct packed {
        logic        pcsel;
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic        auto_gnt;
    int          lat;
    logic        pend_valid;
    logic [31:0] pend_addr;
    int          pend_cnt;
    logic        discard;
    vec_t        vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    // One clock cycle: drive memory response, score consumption, advance.
    task automatic tick();
        logic        rv;
        logic        gr;
        logic [31:0] ga;
        exp_t        e;
        imem_gnt_i    = auto_gnt;
        rv            = pend_valid && (pend_cnt == 0);
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? (pend_addr + 32'h100) : 32'hDEAD_BEEF;
        #1;
        if (!rst && inst_valid_o === 1'b1 && stall_i == 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual pc=%h inst=%h expected none", pc_o, inst_o);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", pc_o, e.pc);
                chk("sb_inst", inst_o, e.inst);
            end
        end
        if (pcsel_i) exp_q.delete();
        gr = (imem_req_o === 1'b1) && imem_gnt_i;
        ga = imem_addr_o;
        if (rv) begin
            if (!pcsel_i && !discard && !rst)
                exp_q.push_back('{pc: pend_addr, inst: pend_addr + 32'h100});
            discard = 1'b0;
        end
        if (pcsel_i) discard = (pend_valid && !rv) || gr;
        @(posedge clk);
        #1;
        if (rv) pend_valid = 1'b0;
        if (gr) begin
            pend_valid = 1'b1;
            pend_addr  = ga;
            pend_cnt   = lat;
        end else if (pend_valid && pend_cnt > 0) begin
            pend_cnt--;
        end
    endtask

    task automatic clear_mem();
        pend_valid = 1'b0;
        pend_cnt   = 0;
        discard    = 1'b0;
        exp_q.delete();
    endtask

    // Leaves the bench at cycle 0 after reset (FSM in IDLE).
    task automatic do_reset();
        rst     = 1'b1;
        pcsel_i = 1'b0;
        stall_i = 1'b0;
        tick();
        tick();
        clear_mem();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles, input logic [31:0] exp_pc, input string name);
        logic got;
        got = 1'b0;
        for (int k = 0; k < max_cycles; k++) begin
            if (inst_valid_o === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual no valid expected pc=%h", name, exp_pc);
        end else begin
            chk({name, "_pc"}, pc_o, exp_pc);
            chk({name, "_inst"}, inst_o, exp_pc + 32'h100);
        end
    endtask

    initial begin
        rst = 1'b1; pcsel_i = 1'b0; alu_target_i = 32'h0; stall_i = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
        auto_gnt = 1'b1; lat = 0;
        clear_mem();

        // Zero-wait memory, cycle by cycle from reset release.
        vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, NOP};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, NOP};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 32'h4, 1'b0, 32'h0, NOP};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h4, 1'b1, 32'h0, 32'h100};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h8, 1'b0, 32'h0, NOP};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h8, 1'b1, 32'h4, 32'h104};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 32'hC, 1'b0, 32'h4, NOP};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 32'hC, 1'b1, 32'h8, 32'h108};

        // --- sequential fetch, plus wrap on the second instance
        do_reset();
        chk("rst_flush", {31'b0, flush_o}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            pcsel_i = vecs[i].pcsel;
            stall_i = vecs[i].stall;
            #1;
            chk($sformatf("seq%0d_req", i), {31'b0, imem_req_o}, {31'b0, vecs[i].exp_req});
            chk($sformatf("seq%0d_addr", i), imem_addr_o, vecs[i].exp_addr);
            chk($sformatf("seq%0d_valid", i), {31'b0, inst_valid_o}, {31'b0, vecs[i].exp_valid});
            chk($sformatf("seq%0d_pc", i), pc_o, vecs[i].exp_pc);
            chk($sformatf("seq%0d_inst", i), inst_o, vecs[i].exp_inst);
            chk($sformatf("seq%0d_wrap_valid", i), {31'b0, u2_valid}, {31'b0, vecs[i].exp_valid});
            if (vecs[i].exp_req)
                chk($sformatf("seq%0d_wrap_addr", i), u2_addr, vecs[i].exp_addr - 32'd4);
            tick();
        end

        // --- redirect while waiting for a slow response
        do_reset();
        lat = 2;
        tick();
        tick();
        chk("rw_req_wait", {31'b0, imem_req_o}, 32'h0);
        pcsel_i = 1'b1; alu_target_i = 32'h2003;
        #1;
        chk("rw_flush", {31'b0, flush_o}, 32'h1);
        tick();
        pcsel_i = 1'b0;
        #1;
        chk("rw_flush_off", {31'b0, flush_o}, 32'h0);
        chk("rw_addr", imem_addr_o, 32'h2000);
        chk("rw_req_drop", {31'b0, imem_req_o}, 32'h0);
        tick();
        chk("rw_valid_late", {31'b0, inst_valid_o}, 32'h0);
        tick();
        chk("rw_valid_after", {31'b0, inst_valid_o}, 32'h0);
        chk("rw_req_target", {31'b0, imem_req_o}, 32'h1);
        chk("rw_addr_target", imem_addr_o, 32'h2000);
        wait_valid(20, 32'h2000, "rw_first");

        // --- redirect in the grant cycle of 0x8
        do_reset();
        lat = 0;
        for (int k = 0; k < 5; k++) tick();
        chk("rg_grant_addr", imem_addr_o, 32'h8);
        pcsel_i = 1'b1; alu_target_i = 32'h3000;
        #1;
        chk("rg_flush", {31'b0, flush_o}, 32'h1);
        tick();
        pcsel_i = 1'b0;
        chk("rg_req_drop", {31'b0, imem_req_o}, 32'h0);
        chk("rg_valid_drop", {31'b0, inst_valid_o}, 32'h0);
        tick();
        chk("rg_valid_after", {31'b0, inst_valid_o}, 32'h0);
        chk("rg_req", {31'b0, imem_req_o}, 32'h1);
        chk("rg_addr", imem_addr_o, 32'h3000);
        wait_valid(20, 32'h3000, "rg_first");

        // --- stall fills the skid, release drains it
        do_reset();
        lat = 0;
        for (int k = 0; k < 5; k++) tick();
        stall_i = 1'b1;
        tick();
        chk("sk_hold_pc", pc_o, 32'h4);
        chk("sk_hold_valid", {31'b0, inst_valid_o}, 32'h1);
        tick();
        chk("sk_full_req", {31'b0, imem_req_o}, 32'h0);
        chk("sk_full_inst", inst_o, 32'h104);
        tick();
        chk("sk_full_req2", {31'b0, imem_req_o}, 32'h0);
        stall_i = 1'b0;
        tick();
        chk("sk_drain_pc", pc_o, 32'h8);
        chk("sk_drain_inst", inst_o, 32'h108);
        chk("sk_drain_valid", {31'b0, inst_valid_o}, 32'h1);
        chk("sk_resume_req", {31'b0, imem_req_o}, 32'h1);
        chk("sk_resume_addr", imem_addr_o, 32'hC);
        tick();

        // --- redirect with stall and full skid
        do_reset();
        lat = 0;
        for (int k = 0; k < 5; k++) tick();
        stall_i = 1'b1;
        tick();
        tick();
        chk("rs_skid_req", {31'b0, imem_req_o}, 32'h0);
        pcsel_i = 1'b1; alu_target_i = 32'h4000;
        #1;
        chk("rs_flush", {31'b0, flush_o}, 32'h1);
        tick();
        pcsel_i = 1'b0; stall_i = 1'b0;
        chk("rs_valid", {31'b0, inst_valid_o}, 32'h0);
        chk("rs_inst", inst_o, NOP);
        chk("rs_req", {31'b0, imem_req_o}, 32'h1);
        chk("rs_addr", imem_addr_o, 32'h4000);
        wait_valid(20, 32'h4000, "rs_first");

        // --- reset asserted during WAIT
        do_reset();
        lat = 3;
        for (int k = 0; k < 3; k++) tick();
        chk("rr_pre_valid", {31'b0, inst_valid_o}, 32'h0);
        tick();
        tick();
        chk("rr_pre_req", {31'b0, imem_req_o}, 32'h0);
        rst = 1'b1; pcsel_i = 1'b1; alu_target_i = 32'h5000;
        #1;
        chk("rr_flush_in_rst", {31'b0, flush_o}, 32'h0);
        tick();
        chk("rr_req", {31'b0, imem_req_o}, 32'h0);
        chk("rr_addr", imem_addr_o, 32'h0);
        chk("rr_valid", {31'b0, inst_valid_o}, 32'h0);
        chk("rr_pc", pc_o, 32'h0);
        chk("rr_inst", inst_o, NOP);
        chk("rr_wrap_addr", u2_addr, 32'hFFFF_FFFC);
        pcsel_i = 1'b0; rst = 1'b0;
        clear_mem();
        tick();
        chk("rr_first_req", {31'b0, imem_req_o}, 32'h1);
        chk("rr_first_addr", imem_addr_o, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
